// File: rtl/axi_pkg.sv
// Shared AXI read-path definitions: arbiter FSM states, response codes and small helpers.
package axi_pkg;

    // Arbiter phases: wait for a request, issue the address, stream the burst back.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } arb_state_e;

    // AXI read/write response encodings.
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Turns a master index into a one-hot select vector.
    function automatic logic [1:0] grant_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin decision: a lone requester wins, a tie goes to the master that
// was not granted last time.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    // Pick the winner for the current request vector.
    always_comb begin
        valid = |req;
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_master_arbiter_r.sv
// Read-channel arbiter for two AXI masters sharing one downstream read port. One burst is in
// flight at a time; the grant is registered in IDLE and held until the last R beat is accepted.
module axi_master_arbiter_r
    import axi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned USER_WIDTH = 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,

    // Master 0 read-address channel
    input  logic [ID_WIDTH-1:0]   m0_ARID,
    input  logic [ADDR_WIDTH-1:0] m0_ARADDR,
    input  logic [7:0]            m0_ARLEN,
    input  logic [2:0]            m0_ARSIZE,
    input  logic [1:0]            m0_ARBURST,
    input  logic                  m0_ARVALID,
    output logic                  m0_ARREADY,
    // Master 0 read-data channel
    output logic [ID_WIDTH-1:0]   m0_RID,
    output logic [DATA_WIDTH-1:0] m0_RDATA,
    output logic [1:0]            m0_RRESP,
    output logic                  m0_RLAST,
    output logic [USER_WIDTH-1:0] m0_RUSER,
    output logic                  m0_RVALID,
    input  logic                  m0_RREADY,

    // Master 1 read-address channel
    input  logic [ID_WIDTH-1:0]   m1_ARID,
    input  logic [ADDR_WIDTH-1:0] m1_ARADDR,
    input  logic [7:0]            m1_ARLEN,
    input  logic [2:0]            m1_ARSIZE,
    input  logic [1:0]            m1_ARBURST,
    input  logic                  m1_ARVALID,
    output logic                  m1_ARREADY,
    // Master 1 read-data channel
    output logic [ID_WIDTH-1:0]   m1_RID,
    output logic [DATA_WIDTH-1:0] m1_RDATA,
    output logic [1:0]            m1_RRESP,
    output logic                  m1_RLAST,
    output logic [USER_WIDTH-1:0] m1_RUSER,
    output logic                  m1_RVALID,
    input  logic                  m1_RREADY,

    // Shared downstream read-address channel
    output logic [ID_WIDTH-1:0]   s_ARID,
    output logic [ADDR_WIDTH-1:0] s_ARADDR,
    output logic [7:0]            s_ARLEN,
    output logic [2:0]            s_ARSIZE,
    output logic [1:0]            s_ARBURST,
    output logic                  s_ARVALID,
    input  logic                  s_ARREADY,
    // Shared downstream read-data channel
    input  logic [ID_WIDTH-1:0]   s_RID,
    input  logic [DATA_WIDTH-1:0] s_RDATA,
    input  logic [1:0]            s_RRESP,
    input  logic                  s_RLAST,
    input  logic [USER_WIDTH-1:0] s_RUSER,
    input  logic                  s_RVALID,
    output logic                  s_RREADY
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;

    logic       arb_grant;
    logic       arb_valid;
    logic       in_addr;
    logic       in_data;
    logic [1:0] own;

    rr_arbiter_2 u_rr_arbiter_2 (
        .req        ({m1_ARVALID, m0_ARVALID}),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    // State, grant and round-robin history; reset leaves master 0 as the first tie winner.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state: arbitrate only in IDLE, then follow the AR and final R handshakes.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    grant_d      = arb_grant;
                    last_grant_d = arb_grant;
                    state_d      = StAddr;
                end
            end
            StAddr: begin
                if (s_ARVALID && s_ARREADY) begin
                    state_d = StData;
                end
            end
            StData: begin
                // Intermediate beats leave the state alone; only the last beat ends the burst.
                if (s_RVALID && s_RREADY && s_RLAST) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Phase qualifiers and one-hot owner select shared by both routing blocks.
    always_comb begin
        in_addr = (state_q == StAddr);
        in_data = (state_q == StData);
        own     = grant_onehot(grant_q);
    end

    // Read-address routing: granted master drives the slave port during ADDR only.
    always_comb begin
        s_ARID     = '0;
        s_ARADDR   = '0;
        s_ARLEN    = '0;
        s_ARSIZE   = '0;
        s_ARBURST  = '0;
        s_ARVALID  = 1'b0;
        m0_ARREADY = 1'b0;
        m1_ARREADY = 1'b0;
        if (in_addr) begin
            if (own[1]) begin
                s_ARID     = m1_ARID;
                s_ARADDR   = m1_ARADDR;
                s_ARLEN    = m1_ARLEN;
                s_ARSIZE   = m1_ARSIZE;
                s_ARBURST  = m1_ARBURST;
                s_ARVALID  = m1_ARVALID;
                m1_ARREADY = s_ARREADY;
            end else begin
                s_ARID     = m0_ARID;
                s_ARADDR   = m0_ARADDR;
                s_ARLEN    = m0_ARLEN;
                s_ARSIZE   = m0_ARSIZE;
                s_ARBURST  = m0_ARBURST;
                s_ARVALID  = m0_ARVALID;
                m0_ARREADY = s_ARREADY;
            end
        end
    end

    // Read-data routing: slave beats reach only the granted master during DATA; others see 0.
    always_comb begin
        m0_RID    = '0;
        m0_RDATA  = '0;
        m0_RRESP  = '0;
        m0_RLAST  = 1'b0;
        m0_RUSER  = '0;
        m0_RVALID = 1'b0;
        m1_RID    = '0;
        m1_RDATA  = '0;
        m1_RRESP  = '0;
        m1_RLAST  = 1'b0;
        m1_RUSER  = '0;
        m1_RVALID = 1'b0;
        s_RREADY  = 1'b0;
        if (in_data) begin
            if (own[1]) begin
                m1_RID    = s_RID;
                m1_RDATA  = s_RDATA;
                m1_RRESP  = s_RRESP;
                m1_RLAST  = s_RLAST;
                m1_RUSER  = s_RUSER;
                m1_RVALID = s_RVALID;
                s_RREADY  = m1_RREADY;
            end else begin
                m0_RID    = s_RID;
                m0_RDATA  = s_RDATA;
                m0_RRESP  = s_RRESP;
                m0_RLAST  = s_RLAST;
                m0_RUSER  = s_RUSER;
                m0_RVALID = s_RVALID;
                s_RREADY  = m0_RREADY;
            end
        end
    end

endmodule
